shift_sub_divider: RTL and testbench
====================================

SHIFT_SUB_DIVIDER -- requirements
Module: shift_sub_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 16, giving the bit width of dividend, divisor, quotient and remainder (legal range 2..64).
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port start  input  1  request a new division; sampled only in IDLE.
REQ-005 SHALL have port dividend  input  WIDTH  numerator, captured when start is accepted.
REQ-006 SHALL have port divisor  input  WIDTH  denominator, captured when start is accepted.
REQ-007 SHALL have port busy  output  1  high from the cycle after acceptance until done.
REQ-008 SHALL have port done  output  1  one-cycle pulse when results are valid.
REQ-009 SHALL have port quotient  output  WIDTH  registered result, held until the next done.
REQ-010 SHALL have port remainder  output  WIDTH  registered result, held until the next done.
REQ-011 SHALL have port div_by_zero  output  1  flag qualified by done, held with the results.

Function
REQ-012 SHALL implement the FSM IDLE -> RUN -> IDLE, plus FIX between RUN and IDLE when signed support is compiled in.
REQ-013 SHALL accept start only in IDLE; start in any other state is ignored with no side effects.
REQ-014 SHALL perform one restoring shift-subtract step per RUN cycle, using a WIDTH+1-bit partial remainder and a step counter that runs from WIDTH-1 down to 0.
REQ-015 SHALL assert done exactly WIDTH+1 edges after the edge that accepts start (unsigned build).
REQ-016 SHALL assert busy for exactly WIDTH cycles, deasserting in the same cycle done rises.
REQ-017 SHALL, when divisor==0, skip RUN, pulse done 1 edge after acceptance, set quotient to all ones, set remainder to dividend, and set div_by_zero=1.
REQ-018 SHALL clear div_by_zero on every non-zero-divisor completion.
REQ-019 SHALL accept a start asserted in the same cycle as done, because the FSM is already in IDLE in that cycle; back-to-back throughput is therefore one division per WIDTH+1 cycles.
REQ-020 SHALL produce quotient = floor(dividend/divisor) and remainder = dividend - quotient*divisor, with remainder < divisor, for all unsigned inputs.
REQ-021 SHALL not change quotient, remainder or div_by_zero except in the cycle done is asserted.

Reset
REQ-022 SHALL, when rst_n is low, immediately force state=IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0 and the counter to 0.
REQ-023 SHALL abandon any in-flight division on reset; no done pulse follows for that division after rst_n rises.
REQ-024 SHALL accept start on the first rising edge at which rst_n is high.

Configuration
REQ-025 SHALL compile in two's-complement signed operation only when macro SHIFT_SUB_DIVIDER_SIGNED_EN is defined.
REQ-026 SHALL, with the macro defined, take operand magnitudes at capture, add the FIX cycle (done at WIDTH+2 edges after acceptance), truncate the quotient toward zero, give the remainder the sign of the dividend, and wrap the most-negative/-1 case to quotient = most-negative, remainder 0.
REQ-027 SHALL, with the macro undefined, treat all operands as unsigned, omit the FIX state entirely, and use the latency given in REQ-015.

Structure
REQ-028 SHALL place the FSM state enum and the clog2-based counter-width helper in the shared package divider_pkg.
REQ-029 SHALL place the single combinational restoring step (shift, trial subtract, select, quotient bit) in sub-module div_sub_step, instantiated once.

Verification
REQ-030 SHALL cover: WIDTH=8, dividend=100, divisor=7, start at edge 0 -> done at edge 9, quotient=14, remainder=2, div_by_zero=0.
REQ-031 SHALL cover: WIDTH=8, 255/0 -> done at edge 1, quotient=8'hFF, remainder=255, div_by_zero=1; the following 10/3 -> quotient=3, remainder=1, div_by_zero=0.
REQ-032 SHALL cover: start pulsed again at edge 4 during 200/9 -> ignored; a single done at edge 9 with quotient=22, remainder=2.
REQ-033 SHALL cover: rst_n low at edge 5 of a division -> all outputs 0 at once; no done pulse follows; the next 9/3 -> quotient=3, remainder=0.
REQ-034 SHALL cover: start held high across the done cycle -> the second division is accepted at the done edge and completes WIDTH+1 edges later.
REQ-035 SHALL cover, with SHIFT_SUB_DIVIDER_SIGNED_EN: WIDTH=8, -7/2 -> quotient=-3, remainder=-1, done at edge 10; -128/-1 -> quotient=-128, remainder=0.

Source files
------------

// File: rtl/divider_pkg.sv
// Shared types and helpers for the shift-subtract divider.
//   state_t   : FSM state encoding (FIX exists only in the signed build)
//   cnt_width : step-counter width for a given operand width
// Build option: SHIFT_SUB_DIVIDER_SIGNED_EN enables two's-complement operation.
package divider_pkg;

`ifdef SHIFT_SUB_DIVIDER_SIGNED_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_t;
`else
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;
`endif

  // Counter must hold WIDTH-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w <= 1) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/div_sub_step.sv
// One combinational restoring division step: shift the next dividend bit
// into the partial remainder, trial-subtract the divisor, keep the
// difference if it did not borrow, and report the resulting quotient bit.
// Ports:
//   i_rem    [WIDTH:0]   partial remainder before the step
//   i_bit                next dividend bit (MSB first)
//   i_dvs    [WIDTH-1:0] divisor magnitude
//   o_rem_c  [WIDTH:0]   partial remainder after the step
//   o_qbit_c             quotient bit produced by this step
module div_sub_step
  import divider_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH:0]   i_rem,
  input  logic             i_bit,
  input  logic [WIDTH-1:0] i_dvs,
  output logic [WIDTH:0]   o_rem_c,
  output logic             o_qbit_c
);

  logic [WIDTH+1:0] w_shift;
  logic [WIDTH+1:0] w_diff;

  // Extra top bit turns the borrow of the trial subtract into a sign bit.
  assign w_shift  = {i_rem, i_bit};
  assign w_diff   = w_shift - {2'b00, i_dvs};
  assign o_qbit_c = ~w_diff[WIDTH+1];
  assign o_rem_c  = o_qbit_c ? w_diff[WIDTH:0] : w_shift[WIDTH:0];

endmodule

// File: rtl/shift_sub_divider.sv
// Multi-cycle restoring shift-subtract divider, one quotient bit per cycle.
// Results are staged in working registers and published to the output
// registers one cycle after the last step, together with the done pulse.
// Build option: SHIFT_SUB_DIVIDER_SIGNED_EN adds two's-complement support
// (magnitudes at capture, sign fix-up in a FIX cycle, +1 cycle latency).
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               request a division (sampled in IDLE only)
//   dividend, divisor   operands, captured on acceptance
//   busy                high while a division is in progress
//   done                one-cycle pulse when results are valid
//   quotient, remainder results, held until the next done
//   div_by_zero         divisor was zero, qualified by done
module shift_sub_divider
  import divider_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CNT_W = cnt_width(WIDTH);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH:0]   r_rem;
  logic [WIDTH:0]   w_rem_nxt;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] w_quo_nxt;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] w_dvs_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_fin;
  logic             w_fin_nxt;
  logic             r_dbz;
  logic             w_dbz_nxt;
  logic             w_zero;
  logic [WIDTH-1:0] w_dvd_op;
  logic [WIDTH-1:0] w_dvs_op;
  logic [WIDTH:0]   w_step_rem;
  logic             w_step_qbit;

  assign w_zero = (divisor == '0);

`ifdef SHIFT_SUB_DIVIDER_SIGNED_EN
  logic r_neg_q;
  logic w_neg_q_nxt;
  logic r_neg_r;
  logic w_neg_r_nxt;

  // Unsigned magnitudes; most-negative maps to itself, which is its correct
  // unsigned magnitude.
  assign w_dvd_op = dividend[WIDTH-1] ? WIDTH'(-dividend) : dividend;
  assign w_dvs_op = divisor[WIDTH-1]  ? WIDTH'(-divisor)  : divisor;
`else
  assign w_dvd_op = dividend;
  assign w_dvs_op = divisor;
`endif

  div_sub_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_rem    (r_rem),
    .i_bit    (r_quo[WIDTH-1]),
    .i_dvs    (r_dvs),
    .o_rem_c  (w_step_rem),
    .o_qbit_c (w_step_qbit)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; a zero divisor never leaves IDLE
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start && !w_zero) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
`ifdef SHIFT_SUB_DIVIDER_SIGNED_EN
        if (r_cnt == '0) w_state_nxt = ST_FIX;
`else
        if (r_cnt == '0) w_state_nxt = ST_IDLE;
`endif
      end
`ifdef SHIFT_SUB_DIVIDER_SIGNED_EN
      ST_FIX:  w_state_nxt = ST_IDLE;
`endif
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Datapath/output next values
  always_comb begin
    w_rem_nxt = r_rem;
    w_quo_nxt = r_quo;
    w_dvs_nxt = r_dvs;
    w_cnt_nxt = r_cnt;
    w_fin_nxt = 1'b0;
    w_dbz_nxt = r_dbz;
`ifdef SHIFT_SUB_DIVIDER_SIGNED_EN
    w_neg_q_nxt = r_neg_q;
    w_neg_r_nxt = r_neg_r;
`endif
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (w_zero) begin
            w_quo_nxt = '1;
            w_rem_nxt = {1'b0, dividend};
            w_dbz_nxt = 1'b1;
            w_fin_nxt = 1'b1;
          end else begin
            // Dividend sits in the quotient register and is shifted out MSB
            // first while quotient bits shift in at the bottom.
            w_rem_nxt = '0;
            w_quo_nxt = w_dvd_op;
            w_dvs_nxt = w_dvs_op;
            w_cnt_nxt = CNT_W'(WIDTH - 1);
            w_dbz_nxt = 1'b0;
`ifdef SHIFT_SUB_DIVIDER_SIGNED_EN
            w_neg_q_nxt = dividend[WIDTH-1] ^ divisor[WIDTH-1];
            w_neg_r_nxt = dividend[WIDTH-1];
`endif
          end
        end
      end
      ST_RUN: begin
        w_rem_nxt = w_step_rem;
        w_quo_nxt = {r_quo[WIDTH-2:0], w_step_qbit};
        w_cnt_nxt = CNT_W'(r_cnt - 1'b1);
`ifndef SHIFT_SUB_DIVIDER_SIGNED_EN
        if (r_cnt == '0) w_fin_nxt = 1'b1;
`endif
      end
`ifdef SHIFT_SUB_DIVIDER_SIGNED_EN
      ST_FIX: begin
        // Truncation toward zero; remainder follows the dividend's sign.
        w_quo_nxt = r_neg_q ? WIDTH'(-r_quo) : r_quo;
        w_rem_nxt = {1'b0, r_neg_r ? WIDTH'(-r_rem[WIDTH-1:0]) : r_rem[WIDTH-1:0]};
        w_fin_nxt = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  // Working registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem <= '0;
      r_quo <= '0;
      r_dvs <= '0;
      r_cnt <= '0;
      r_fin <= 1'b0;
      r_dbz <= 1'b0;
`ifdef SHIFT_SUB_DIVIDER_SIGNED_EN
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
`endif
    end else begin
      r_rem <= w_rem_nxt;
      r_quo <= w_quo_nxt;
      r_dvs <= w_dvs_nxt;
      r_cnt <= w_cnt_nxt;
      r_fin <= w_fin_nxt;
      r_dbz <= w_dbz_nxt;
`ifdef SHIFT_SUB_DIVIDER_SIGNED_EN
      r_neg_q <= w_neg_q_nxt;
      r_neg_r <= w_neg_r_nxt;
`endif
    end
  end

  // Output registers; results only move on the done cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      busy <= (r_state != ST_IDLE);
      done <= r_fin;
      if (r_fin) begin
        quotient    <= r_quo;
        remainder   <= r_rem[WIDTH-1:0];
        div_by_zero <= r_dbz;
      end
    end
  end

endmodule

// File: tb/tb_shift_sub_divider.sv
// Directed bench for shift_sub_divider at WIDTH=8.
module tb_shift_sub_divider;

  localparam int unsigned W = 8;
`ifdef SHIFT_SUB_DIVIDER_SIGNED_EN
  localparam int LAT   = 10;
  localparam int BUSYN = 9;
`else
  localparam int LAT   = 9;
  localparam int BUSYN = 8;
`endif

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int n_checks = 0;
  int n_fail   = 0;

  shift_sub_divider #(
    .WIDTH (W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 'h%0h required 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One division: edge 0 accepts; optional extra start pulse sampled at edge repulse.
  task automatic run_div(input string tag, input logic [W-1:0] dvd, input logic [W-1:0] dvs,
                         input logic [W-1:0] eq, input logic [W-1:0] er, input logic ez,
                         input int elat, input int ebusy, input int repulse);
    int n;
    int nbusy;
    logic got;
    dividend = dvd;
    divisor  = dvs;
    start    = 1'b1;
    tick();
    start = 1'b0;
    n     = 0;
    nbusy = 0;
    got   = 1'b0;
    while (!got && n < 40) begin
      tick();
      n++;
      if (busy) nbusy++;
      if (done) got = 1'b1;
      if (n + 1 == repulse) begin
        start    = 1'b1;
        dividend = 8'd50;
        divisor  = 8'd5;
      end
      if (n == repulse) start = 1'b0;
    end
    check({tag, " done_seen"}, 64'(got), 64'd1);
    check({tag, " latency"}, 64'(n), 64'(elat));
    check({tag, " busy_cycles"}, 64'(nbusy), 64'(ebusy));
    check({tag, " busy_at_done"}, 64'(busy), 64'd0);
    check({tag, " quotient"}, 64'(quotient), 64'(eq));
    check({tag, " remainder"}, 64'(remainder), 64'(er));
    check({tag, " div_by_zero"}, 64'(div_by_zero), 64'(ez));
    tick();
    check({tag, " done_one_cycle"}, 64'(done), 64'd0);
    check({tag, " quotient_held"}, 64'(quotient), 64'(eq));
  endtask

  initial begin
    int n;
    int ndone;
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;

    // Reset values
    #2;
    check("rst busy", 64'(busy), 64'd0);
    check("rst done", 64'(done), 64'd0);
    check("rst quotient", 64'(quotient), 64'd0);
    check("rst remainder", 64'(remainder), 64'd0);
    check("rst div_by_zero", 64'(div_by_zero), 64'd0);

    // Release between edges; first edge with rst_n high accepts start
    #10;
    rst_n = 1'b1;
    run_div("100/7", 8'd100, 8'd7, 8'd14, 8'd2, 1'b0, LAT, BUSYN, 0);

    run_div("255/0", 8'd255, 8'd0, 8'hFF, 8'd255, 1'b1, 1, 0, 0);
    run_div("10/3", 8'd10, 8'd3, 8'd3, 8'd1, 1'b0, LAT, BUSYN, 0);

`ifdef SHIFT_SUB_DIVIDER_SIGNED_EN
    run_div("200/9 restart", 8'd200, 8'd9, 8'hFA, 8'hFE, 1'b0, LAT, BUSYN, 4);
`else
    run_div("200/9 restart", 8'd200, 8'd9, 8'd22, 8'd2, 1'b0, LAT, BUSYN, 4);
`endif

    run_div("255/1", 8'd255, 8'd1, 8'hFF, 8'd0, 1'b0, LAT, BUSYN, 0);
    run_div("5/200", 8'd5, 8'd200, 8'd0, 8'd5, 1'b0, LAT, BUSYN, 0);

    // Reset in the middle of a division
    dividend = 8'd77;
    divisor  = 8'd4;
    start    = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    check("midrst busy", 64'(busy), 64'd0);
    check("midrst done", 64'(done), 64'd0);
    check("midrst quotient", 64'(quotient), 64'd0);
    check("midrst remainder", 64'(remainder), 64'd0);
    check("midrst div_by_zero", 64'(div_by_zero), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (done) ndone++;
    end
    check("midrst no_done", 64'(ndone), 64'd0);
    run_div("9/3", 8'd9, 8'd3, 8'd3, 8'd0, 1'b0, LAT, BUSYN, 0);

    // Start held across done: second division accepted at the done edge
    dividend = 8'd100;
    divisor  = 8'd7;
    start    = 1'b1;
    tick();
    dividend = 8'd120;
    divisor  = 8'd16;
    n = 0;
    while (!done && n < 40) begin
      tick();
      n++;
    end
    start = 1'b0;
    check("b2b first latency", 64'(n), 64'(LAT));
    check("b2b first quotient", 64'(quotient), 64'd14);
    check("b2b first remainder", 64'(remainder), 64'd2);
    n = 0;
    tick();
    n++;
    while (!done && n < 40) begin
      tick();
      n++;
    end
    check("b2b second latency", 64'(n), 64'(LAT));
    check("b2b second quotient", 64'(quotient), 64'd7);
    check("b2b second remainder", 64'(remainder), 64'd8);
    tick();

`ifdef SHIFT_SUB_DIVIDER_SIGNED_EN
    run_div("-7/2", 8'hF9, 8'd2, 8'hFD, 8'hFF, 1'b0, 10, 9, 0);
    run_div("-128/-1", 8'h80, 8'hFF, 8'h80, 8'd0, 1'b0, 10, 9, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
